// File: rtl/up_down_counter_4bit.sv
// up_down_counter_4bit
// Free-running modulo-2^WIDTH up/down counter. It advances on every rising
// clk edge. mode selects the direction: 0 counts up and 1 counts down.
// rst is synchronous, active-high, and takes priority over mode.
// count is driven straight from the state register.

module up_down_counter_4bit #(
    parameter int unsigned          WIDTH       = 4,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;

    // Next count: increment or decrement, wrapping naturally modulo 2^WIDTH
    always_comb begin
        w_next = r_count;
        if (mode) begin
            w_next = r_count - WIDTH'(1);
        end else begin
            w_next = r_count + WIDTH'(1);
        end
    end

    // Count register with synchronous reset overriding the direction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= RESET_VALUE;
        end else begin
            r_count <= w_next;
        end
    end

    assign count = r_count;

endmodule

// File: tb/tb_up_down_counter_4bit.sv
// Self-checking bench for up_down_counter_4bit.
// It runs directed sequences at the documented edge times, then random
// mode/rst traffic. All of it is checked against a modulo-16 arithmetic
// reference model.

module tb_up_down_counter_4bit;

    logic       clk;
    logic       rst;
    logic       mode;
    logic [3:0] count;

    int checks;
    int errors;
    int exp_cnt;

    up_down_counter_4bit #(
        .WIDTH       (4),
        .RESET_VALUE (4'd0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .mode  (mode),
        .count (count)
    );

    // 10 ns period, rising edges at 5, 15, 25, ... ns
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait for a rising edge, update the reference model from the inputs
    // applied at that edge, then check count 1 ns later
    task automatic tick(input string tag);
        logic r_s;
        logic m_s;
        @(posedge clk);
        r_s = rst;
        m_s = mode;
        if (r_s)
            exp_cnt = 0;
        else if (m_s)
            exp_cnt = (exp_cnt + 15) % 16;
        else
            exp_cnt = (exp_cnt + 1) % 16;
        #1;
        chk(tag, count, 4'(exp_cnt));
    endtask

    // Change inputs 6 ns after the post-edge sample point (edge + 7 ns)
    task automatic drive(input logic r, input logic m);
        #6;
        rst  = r;
        mode = m;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 0;

        // 1. reset, then count up
        rst  = 1'b1;
        mode = 1'b0;
        tick("reset");
        drive(1'b0, 1'b0);                     // 12 ns
        for (int i = 0; i < 10; i++) tick("up");
        chk("up_at_105", count, 4'd10);

        // 2. count down from 10
        drive(1'b0, 1'b1);                     // 112 ns
        for (int i = 0; i < 8; i++) tick("down");
        chk("down_at_185", count, 4'd2);

        // 3. back to up with no dead cycle
        drive(1'b0, 1'b0);                     // 192 ns
        tick("dir_change");
        chk("dir_change_first", count, 4'd3);
        for (int i = 0; i < 5; i++) tick("up2");
        chk("up_at_245", count, 4'd8);

        // 4. up wrap from 14
        for (int i = 0; i < 6; i++) tick("to14");
        chk("at14", count, 4'd14);
        tick("wrap_up"); chk("wrap_up_15", count, 4'd15);
        tick("wrap_up"); chk("wrap_up_0", count, 4'd0);
        tick("wrap_up"); chk("wrap_up_1", count, 4'd1);

        // down wrap from 1
        drive(1'b0, 1'b1);
        tick("wrap_dn"); chk("wrap_dn_0", count, 4'd0);
        tick("wrap_dn"); chk("wrap_dn_15", count, 4'd15);
        tick("wrap_dn"); chk("wrap_dn_14", count, 4'd14);

        // 5. mid-operation reset at count 7 while counting down
        for (int i = 0; i < 7; i++) tick("to7");
        chk("at7", count, 4'd7);
        drive(1'b1, 1'b1);
        tick("mid_reset"); chk("mid_reset_0", count, 4'd0);
        drive(1'b0, 1'b1);
        tick("after_reset"); chk("after_reset_15", count, 4'd15);

        // 6. rst and mode glitches that never span a rising edge
        for (int k = 0; k < 3; k++) begin
            #2 rst = 1'b1;
            #2 mode = ~mode;
            #1 chk("glitch_stable", count, 4'(exp_cnt));
            #1 begin rst = 1'b0; mode = 1'b1; end
            #2 chk("glitch_stable2", count, 4'(exp_cnt));
            tick("post_glitch");
        end

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 15) == 0), 1'($urandom));
            tick("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
